// File: rtl/control_sequencer.sv
// control_sequencer: sequencing core of the control unit.
// Holds the instruction register, the 2-bit micro-state and the status flags.
// Gates the decoder control word against the RAM-ready handshake.
// Optional feature macro: CONTROL_SEQUENCER_COND_BRANCH_EN (B.cond evaluation/override).
// Status flag order is {V,C,N,Z,Zb}.
module control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction_in,
  input  logic        fetch_valid,
  input  logic [32:0] cw_in,
  input  logic [4:0]  alu_status,
  input  logic        ram_ready,
  output logic [31:0] instruction,
  output logic [1:0]  state,
  output logic [4:0]  status,
  output logic [32:0] cw_out,
  output logic        stall,
  output logic        cond_taken
);

  typedef enum logic {PH_FETCH = 1'b0, PH_EXEC = 1'b1} phase_t;

  phase_t      r_phase;
  phase_t      w_phase_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [4:0]  r_status;
  logic [4:0]  w_status_nxt;
  logic        w_exec;
  logic        w_stall;
  logic        w_cond_taken;
  logic [32:0] w_cw;

`ifdef CONTROL_SEQUENCER_COND_BRANCH_EN
  // ARM-style condition evaluation against flags {V,C,N,Z,Zb}
  function automatic logic cond_eval(input logic [3:0] cond, input logic [4:0] flags);
    logic v, c, n, z;
    v = flags[4];
    c = flags[3];
    n = flags[2];
    z = flags[1];
    case (cond)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = c;
      4'b0011: cond_eval = ~c;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = c & ~z;
      4'b1001: cond_eval = ~c | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      default: cond_eval = 1'b1;
    endcase
  endfunction
`endif

  assign w_exec  = (r_phase == PH_EXEC);
  // Only an actual RAM access can be held up by ram_ready
  assign w_stall = w_exec & (cw_in[8] | cw_in[7]) & ~ram_ready;

  assign instruction = r_instr;
  assign state       = r_state;
  assign status      = r_status;
  assign stall       = w_stall;
  assign cond_taken  = w_cond_taken;

  // Sequencer registers: phase, instruction, micro-state and status flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase  <= PH_FETCH;
      r_instr  <= 32'd0;
      r_state  <= 2'b00;
      r_status <= 5'd0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_instr  <= w_instr_nxt;
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
    end
  end

  // Next-state logic: fetch latches the instruction, execute steps the micro-state
  always_comb begin
    w_phase_nxt  = r_phase;
    w_instr_nxt  = r_instr;
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    case (r_phase)
      PH_FETCH: begin
        if (fetch_valid) begin
          w_instr_nxt = instruction_in;
          w_state_nxt = 2'b00;
          w_phase_nxt = PH_EXEC;
        end else begin
          w_phase_nxt = PH_FETCH;
        end
      end
      PH_EXEC: begin
        if (!w_stall) begin
          if (cw_in[2]) begin
            w_status_nxt = alu_status;
          end else begin
            w_status_nxt = r_status;
          end
          if (cw_in[1:0] == 2'b00) begin
            w_phase_nxt = PH_FETCH;
          end else begin
            w_state_nxt = cw_in[1:0];
          end
        end else begin
          w_phase_nxt = PH_EXEC;
        end
      end
      default: begin
        w_phase_nxt = PH_FETCH;
      end
    endcase
  end

  // Output control word: zero in fetch, branch override then stall masking in execute
  always_comb begin
    w_cond_taken = 1'b1;
    w_cw         = cw_in;
    cw_out       = 33'd0;
    if (w_exec) begin
`ifdef CONTROL_SEQUENCER_COND_BRANCH_EN
      if (r_instr[31:24] == 8'h54) begin
        w_cond_taken = cond_eval(r_instr[3:0], r_status);
        if (!w_cond_taken) begin
          w_cw[5:4] = 2'b01;
          w_cw[3]   = 1'b0;
        end else begin
          w_cw[5:3] = cw_in[5:3];
        end
      end else begin
        w_cond_taken = 1'b1;
      end
`endif
      if (w_stall) begin
        // Hold the RAM access but suppress every architectural side effect
        w_cw[9]   = 1'b0;
        w_cw[6]   = 1'b0;
        w_cw[5:4] = 2'b00;
        w_cw[2]   = 1'b0;
      end else begin
        w_cw[9] = w_cw[9];
      end
      cw_out = w_cw;
    end else begin
      cw_out = 33'd0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed literal checks plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_control_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] instruction_in;
  logic        fetch_valid;
  logic [32:0] cw_in;
  logic [4:0]  alu_status;
  logic        ram_ready;
  logic [31:0] instruction;
  logic [1:0]  state;
  logic [4:0]  status;
  logic [32:0] cw_out;
  logic        stall;
  logic        cond_taken;

  int n_checks = 0;
  int n_errors = 0;

  control_sequencer dut (
    .clock(clock), .reset(reset), .instruction_in(instruction_in),
    .fetch_valid(fetch_valid), .cw_in(cw_in), .alu_status(alu_status),
    .ram_ready(ram_ready), .instruction(instruction), .state(state),
    .status(status), .cw_out(cw_out), .stall(stall), .cond_taken(cond_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic        m_busy;     // 1 while an instruction is executing
  logic [31:0] m_instr;
  logic [1:0]  m_state;
  logic [4:0]  m_status;

  function automatic logic m_cond(input logic [3:0] c, input logic [4:0] f);
    logic v, cf, n, z, base;
    v = f[4]; cf = f[3]; n = f[2]; z = f[1];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) return !base;
    return base;
  endfunction

  function automatic logic m_stall();
    return m_busy && (cw_in[8] || cw_in[7]) && !ram_ready;
  endfunction

  function automatic logic m_taken();
`ifdef CONTROL_SEQUENCER_COND_BRANCH_EN
    if (m_busy && m_instr[31:24] == 8'h54) return m_cond(m_instr[3:0], m_status);
`endif
    return 1'b1;
  endfunction

  function automatic logic [32:0] m_cw();
    logic [32:0] w;
    if (!m_busy) return 33'd0;
    w = cw_in;
    if (!m_taken()) begin
      w[5:4] = 2'b01;
      w[3]   = 1'b0;
    end
    if (m_stall()) begin
      w[9] = 1'b0; w[6] = 1'b0; w[5:4] = 2'b00; w[2] = 1'b0;
    end
    return w;
  endfunction

  // Model state update, mirroring only the architectural rules
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_instr <= 32'd0; m_state <= 2'd0; m_status <= 5'd0;
    end else if (!m_busy) begin
      if (fetch_valid) begin
        m_instr <= instruction_in; m_state <= 2'd0; m_busy <= 1'b1;
      end
    end else if (!m_stall()) begin
      if (cw_in[2]) m_status <= alu_status;
      if (cw_in[1:0] == 2'd0) m_busy <= 1'b0;
      else m_state <= cw_in[1:0];
    end
  end

  // Single compare process: every output, every cycle, on the falling edge
  always @(negedge clock) begin
    n_checks++;
    if (instruction !== m_instr || state !== m_state || status !== m_status ||
        cw_out !== m_cw() || stall !== m_stall() || cond_taken !== m_taken()) begin
      n_errors++;
      $display("FAIL model t=%0t got instr=%h st=%0d stat=%b cw=%h stall=%b ct=%b want instr=%h st=%0d stat=%b cw=%h stall=%b ct=%b",
               $time, instruction, state, status, cw_out, stall, cond_taken,
               m_instr, m_state, m_status, m_cw(), m_stall(), m_taken());
    end
  end

  // ---------------- directed helpers ----------------
  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] ins, input logic [32:0] cw,
                       input logic [4:0] alu, input logic rdy);
    @(posedge clock);
    #2;
    fetch_valid = fv; instruction_in = ins; cw_in = cw; alu_status = alu; ram_ready = rdy;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    lit({tag, "_instr"}, 64'(instruction), 64'h0);
    lit({tag, "_state"}, 64'(state), 64'h0);
    lit({tag, "_status"}, 64'(status), 64'h0);
    lit({tag, "_cw"}, 64'(cw_out), 64'h0);
    lit({tag, "_stall"}, 64'(stall), 64'h0);
    lit({tag, "_ct"}, 64'(cond_taken), 64'h1);
  endtask

  initial begin
    reset = 1'b0; fetch_valid = 1'b0; instruction_in = 32'd0;
    cw_in = 33'd0; alu_status = 5'd0; ram_ready = 1'b1;
    repeat (2) @(posedge clock);
    sample();
    check_reset_values("por");
    @(posedge clock); #2 reset = 1'b1;

    // single-cycle instruction
    drive(1'b1, 32'h1234_5678, 33'd0, 5'd0, 1'b1);
    drive(1'b0, 32'd0, 33'h1_0000_0200, 5'd0, 1'b1);
    sample();
    lit("single_cw", 64'(cw_out), 64'h1_0000_0200);
    lit("single_instr", 64'(instruction), 64'h1234_5678);
    drive(1'b0, 32'd0, 33'h1_0000_0200, 5'd0, 1'b1);
    sample();
    lit("single_back_fetch", 64'(cw_out), 64'h0);

    // multi-cycle instruction 01,10,00
    drive(1'b1, 32'hABCD_0001, 33'd0, 5'd0, 1'b1);
    drive(1'b0, 32'd0, 33'h0_0000_0001, 5'd0, 1'b1);
    sample(); lit("multi_s0", 64'(state), 64'h0);
    drive(1'b0, 32'd0, 33'h0_0000_0002, 5'd0, 1'b1);
    sample(); lit("multi_s1", 64'(state), 64'h1);
    drive(1'b0, 32'd0, 33'h0_0000_0000, 5'd0, 1'b1);
    sample(); lit("multi_s2", 64'(state), 64'h2);
    drive(1'b0, 32'd0, 33'h0_0000_0374, 5'd0, 1'b1);
    sample(); lit("multi_fetch", 64'(cw_out), 64'h0);

    // RAM stall three cycles, status load suppressed while stalled
    drive(1'b1, 32'h0000_1111, 33'd0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 33'h0_0000_0374, 5'b10010, 1'b0);
      sample();
      lit("stall_flag", 64'(stall), 64'h1);
      lit("stall_cw", 64'(cw_out), 64'h100);
      lit("stall_status", 64'(status), 64'h0);
    end
    drive(1'b0, 32'd0, 33'h0_0000_0374, 5'b10010, 1'b1);
    sample();
    lit("stall_done", 64'(stall), 64'h0);
    lit("stall_done_cw", 64'(cw_out), 64'h374);
    drive(1'b0, 32'd0, 33'd0, 5'd0, 1'b1);
    sample();
    lit("status_loaded", 64'(status), 64'h12);

    // B.cond EQ with Z=0 then Z=1
    drive(1'b1, 32'h0, 33'd0, 5'd0, 1'b1);
    drive(1'b0, 32'd0, 33'h4, 5'b00000, 1'b1);
    drive(1'b1, 32'h5400_0040, 33'd0, 5'd0, 1'b1);
    drive(1'b0, 32'd0, 33'h38, 5'd0, 1'b1);
    sample();
`ifdef CONTROL_SEQUENCER_COND_BRANCH_EN
    lit("beq_nt_cw", 64'(cw_out), 64'h10);
    lit("beq_nt_ct", 64'(cond_taken), 64'h0);
`else
    lit("beq_nt_cw", 64'(cw_out), 64'h38);
    lit("beq_nt_ct", 64'(cond_taken), 64'h1);
`endif
    drive(1'b1, 32'h0, 33'd0, 5'd0, 1'b1);
    drive(1'b0, 32'd0, 33'h4, 5'b00010, 1'b1);
    drive(1'b1, 32'h5400_0040, 33'd0, 5'd0, 1'b1);
    drive(1'b0, 32'd0, 33'h38, 5'd0, 1'b1);
    sample();
    lit("beq_t_cw", 64'(cw_out), 64'h38);
    lit("beq_t_ct", 64'(cond_taken), 64'h1);

    // reset mid-execute with state=10
    drive(1'b1, 32'h7777_7777, 33'd0, 5'd0, 1'b1);
    drive(1'b0, 32'd0, 33'h1, 5'd0, 1'b1);
    drive(1'b0, 32'd0, 33'h2, 5'd0, 1'b1);
    drive(1'b0, 32'd0, 33'h1_0000_0207, 5'd0, 1'b1);
    sample(); lit("pre_reset_state", 64'(state), 64'h2);
    #1 reset = 1'b0;
    #1 check_reset_values("mid");
    drive(1'b0, 32'd0, 33'h1_0000_0207, 5'd0, 1'b1);
    reset = 1'b1;
    sample(); lit("post_reset_cw", 64'(cw_out), 64'h0);
    drive(1'b0, 32'd0, 33'h1_0000_0207, 5'd0, 1'b1);
    sample(); lit("post_reset_hold", 64'(cw_out), 64'h0);

    // randomized stimulus, occasional asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock);
      #2;
      fetch_valid    = 1'($urandom_range(0, 1));
      instruction_in = ($urandom_range(0, 3) == 0) ? {8'h54, 24'($urandom)} : 32'($urandom);
      cw_in          = {1'($urandom_range(0, 1)), 32'($urandom)};
      alu_status     = 5'($urandom);
      ram_ready      = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) reset = 1'b0;
      else reset = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    sample();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
